uart_tx_word_fifo: RTL and testbench
====================================

# uart_tx_word_fifo

Parametrised transmit buffer between the user-project bus registers and the UART byte transmitter. It holds up to DEPTH words of DATA_W bits, each tagged with a byte count. Each word is unpacked into bytes in a configurable order and handed to the transmitter over the start/clear/busy handshake. It adds flush, level and sticky-overflow reporting, which the single-word buffer lacked.

## Interface
- DATA_W, 32, word width; multiple of 8, ≥ 8; NB = DATA_W/8 bytes per word
- DEPTH, 4, FIFO depth in words; power of 2, ≥ 2
- MSB_FIRST, 1, 1: highest valid byte sent first; 0: byte 0 sent first
- NBW (derived), $clog2(NB)+1
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_wr_valid  in  1  push request
- i_wr_data  in  DATA_W  word to push
- i_wr_nbytes  in  NBW  number of valid bytes, taken from the LSB end; 0 = word discarded; >NB clamped to NB
- o_wr_ready  out  1  count < DEPTH (combinational from registered count)
- i_flush  in  1  empty FIFO and abort the word in progress
- i_ovf_clear  in  1  clears o_overflow
- o_overflow  out  1  sticky: push attempted while full
- o_level  out  $clog2(DEPTH)+1  words stored, excluding the word being unpacked
- o_tx_data  out  8  byte to transmitter
- o_tx_start  out  1  byte valid; held until acknowledged
- i_tx_start_clear  in  1  transmitter acknowledge (byte taken)
- i_busy  in  1  transmitter busy
- o_busy  out  1  (state != IDLE) || (count != 0)

## Operation
- Reset (rst_n low at an edge): FIFO pointers and count = 0, state IDLE, o_tx_data = 0, o_tx_start = 0, o_overflow = 0. Hence o_wr_ready = 1, o_level = 0, o_busy = 0.
- Push: accepted when i_wr_valid && o_wr_ready && !i_flush && i_wr_nbytes != 0. Stores {data, clamped nbytes}.
- i_wr_valid && !o_wr_ready sets o_overflow; the word is dropped. If set and i_ovf_clear occur in the same cycle, set wins.
- Push and pop in the same cycle: count unchanged. Ready is evaluated on the pre-edge count, so a pop does not admit a push to a full FIFO in that cycle.
- FSM:
  - IDLE: if count != 0, pop the head word into the shift register, set rem = nbytes, go to WAIT_TX.
  - WAIT_TX: if !i_busy, drive o_tx_data = next byte, o_tx_start = 1, rem = rem-1, go to WAIT_CLR.
  - WAIT_CLR: on i_tx_start_clear, o_tx_start = 0, o_tx_data = 0. Go to WAIT_TX if rem != 0, else IDLE.
- Byte order:
  - MSB_FIRST=1: bytes nbytes-1 down to 0.
  - MSB_FIRST=0: bytes 0 up to nbytes-1.
  - Bytes above nbytes are never sent.
- i_flush: count and pointers = 0, state IDLE, o_tx_start = 0, o_tx_data = 0. Flush has priority over push, pop and clear in the same cycle. The dropped push does not set o_overflow. o_overflow is unaffected by flush.
- i_tx_start_clear outside WAIT_CLR is ignored.

## Timing
- Word accepted at edge E0, FIFO previously empty, FSM idle, i_busy low:
  - Pop at E1.
  - o_tx_start = 1 and byte valid after E2.
- Clear sampled at edge Ek: o_tx_start low after Ek. The next byte's o_tx_start rises after Ek+1 at the earliest (one-cycle low gap guaranteed).
- Last byte cleared at Ek with more words queued: IDLE pops at Ek+1, next start after Ek+2.
- o_level, o_wr_ready and o_busy update in the cycle after the causing edge.
- Reset mid-transfer: all outputs take reset values after that edge. The partial word is lost.

## Test plan
- Reset, then DATA_W=32, MSB_FIRST=1, push 0x41424344 with nbytes=4, i_busy=0, clear one cycle after each start. Required: bytes 0x41, 0x42, 0x43, 0x44; first o_tx_start after E2; o_busy returns to 0.
- MSB_FIRST=0, push 0x11223344 with nbytes=2. Required: bytes 0x44, 0x33 only. Push with nbytes=0: no output, o_level stays 0.
- Hold i_busy=1, push DEPTH+2 words. Required: first word popped, o_level reaches DEPTH, o_wr_ready=0, o_overflow=1 after the extra push. i_ovf_clear together with another overflowing push: o_overflow stays 1.
- i_busy high for 5 cycles in WAIT_TX. Required: o_tx_start stays 0 until i_busy falls, then rises on the next edge. Clear held in WAIT_TX: no effect.
- Flush while in WAIT_CLR with 3 words queued and a push in the same cycle. Required: o_tx_start=0, o_level=0, o_busy=0 next cycle; o_overflow unchanged; later pushes transmit normally.

Source files
------------

// File: rtl/uart_tx_word_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_word_fifo
// Purpose  : Word FIFO feeding a UART byte transmitter; unpacks each word
//            into bytes and drives the start/clear/busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_word_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int NBW      = $clog2(DATA_W / 8) + 1,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [NBW-1:0]    i_wr_nbytes,
    output logic              o_wr_ready,
    input  logic              i_flush,
    input  logic              i_ovf_clear,
    output logic              o_overflow,
    output logic [LW-1:0]     o_level,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_start_clear,
    input  logic              i_busy,
    output logic              o_busy
);

    localparam int c_NB = DATA_W / 8;
    localparam int c_AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_TX  = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [NBW-1:0]    r_mem_nb   [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [LW-1:0]     r_count;
    logic [DATA_W-1:0] r_word;
    logic [NBW-1:0]    r_rem;
    logic              w_push;
    logic              w_pop;
    logic              w_send;
    logic              w_ack;
    logic [NBW-1:0]    w_nb_clamped;
    logic [7:0]        w_byte;

    assign o_wr_ready   = (r_count < LW'(DEPTH));
    assign o_level      = r_count;
    assign o_busy       = (r_state != IDLE) || (r_count != '0);
    assign w_push       = i_wr_valid && o_wr_ready && !i_flush && (i_wr_nbytes != '0);
    assign w_nb_clamped = (i_wr_nbytes > NBW'(c_NB)) ? NBW'(c_NB) : i_wr_nbytes;

    // MSB-first indexes the held word by remaining count; LSB-first shifts it down.
    always_comb begin
        w_byte = r_word[7:0];
        if (MSB_FIRST) begin
            for (int b = 0; b < c_NB; b++) begin
                if (r_rem == NBW'(b + 1)) begin
                    w_byte = r_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_send      = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (!i_busy) begin
                    w_send      = 1'b1;
                    w_state_nxt = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (i_tx_start_clear) begin
                    w_ack       = 1'b1;
                    w_state_nxt = (r_rem != '0) ? WAIT_TX : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = IDLE;
            w_pop       = 1'b0;
            w_send      = 1'b0;
            w_ack       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_wr_data;
            r_mem_nb[r_wr_ptr]   <= w_nb_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_rem      <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            // A push swallowed by flush is not an overflow.
            if (i_wr_valid && !o_wr_ready && !i_flush) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clear) begin
                o_overflow <= 1'b0;
            end

            if (i_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                o_tx_start <= 1'b0;
                o_tx_data  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_word   <= r_mem_data[r_rd_ptr];
                    r_rem    <= r_mem_nb[r_rd_ptr];
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_send) begin
                    o_tx_data  <= w_byte;
                    o_tx_start <= 1'b1;
                    r_rem      <= r_rem - 1'b1;
                    if (!MSB_FIRST) begin
                        r_word <= r_word >> 8;
                    end
                end
                if (w_ack) begin
                    o_tx_start <= 1'b0;
                    o_tx_data  <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_word_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_word_fifo
// Purpose  : Bench for uart_tx_word_fifo; MSB-first and LSB-first instances
//            share stimulus and are checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_word_fifo;

    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        rst_n, wr_valid, flush, ovf_clear, busy;
    logic        tx_clr = 1'b0;
    logic [31:0] wr_data;
    logic [2:0]  wr_nbytes;
    logic        ready_m, ready_l, ovf_m, ovf_l, start_m, start_l, obusy_m, obusy_l;
    logic [2:0]  level_m, level_l;
    logic [7:0]  data_m, data_l;

    int n_tests = 0;
    int n_fail  = 0;
    bit ack_en    = 1'b0;
    bit ack_force = 1'b0;

    always #5 clk = ~clk;

    uart_tx_word_fifo #(.DATA_W(32), .DEPTH(DP), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .i_wr_nbytes(wr_nbytes), .o_wr_ready(ready_m), .i_flush(flush),
        .i_ovf_clear(ovf_clear), .o_overflow(ovf_m), .o_level(level_m),
        .o_tx_data(data_m), .o_tx_start(start_m), .i_tx_start_clear(tx_clr),
        .i_busy(busy), .o_busy(obusy_m)
    );

    uart_tx_word_fifo #(.DATA_W(32), .DEPTH(DP), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .i_wr_nbytes(wr_nbytes), .o_wr_ready(ready_l), .i_flush(flush),
        .i_ovf_clear(ovf_clear), .o_overflow(ovf_l), .o_level(level_l),
        .o_tx_data(data_l), .o_tx_start(start_l), .i_tx_start_clear(tx_clr),
        .i_busy(busy), .o_busy(obusy_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transmitter stand-in: acknowledges one cycle after each start.
    always @(posedge clk) begin
        #1;
        tx_clr = ack_force || (ack_en && start_m);
    end

    // Behavioural model: a word queue plus the byte list of the word in flight.
    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  n;
    } word_t;

    word_t      wq[$];
    logic [7:0] bm[$];
    logic [7:0] bl[$];
    int         phase  = 0;
    logic       e_start = 1'b0;
    logic [7:0] e_dm = 8'h00;
    logic [7:0] e_dl = 8'h00;
    logic       e_ovf = 1'b0;
    bit         m_live = 1'b0;

    always @(posedge clk) begin : p_model
        word_t w;
        bit    rdy;
        int    n;
        if (!rst_n) begin
            wq.delete(); bm.delete(); bl.delete();
            phase = 0; e_start = 1'b0; e_dm = 8'h00; e_dl = 8'h00; e_ovf = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            rdy = (wq.size() < DP);
            if (!flush && wr_valid && !rdy) e_ovf = 1'b1;
            else if (ovf_clear) e_ovf = 1'b0;
            if (flush) begin
                wq.delete(); bm.delete(); bl.delete();
                phase = 0; e_start = 1'b0; e_dm = 8'h00; e_dl = 8'h00;
            end else begin
                case (phase)
                    0: if (wq.size() > 0) begin
                        w = wq.pop_front();
                        n = (w.n > 4) ? 4 : int'(w.n);
                        for (int i = 0; i < n; i++) begin
                            bl.push_back(8'(w.d >> (8 * i)));
                            bm.push_front(8'(w.d >> (8 * i)));
                        end
                        phase = 1;
                    end
                    1: if (!busy) begin
                        e_dm = bm.pop_front();
                        e_dl = bl.pop_front();
                        e_start = 1'b1;
                        phase = 2;
                    end
                    default: if (tx_clr) begin
                        e_start = 1'b0; e_dm = 8'h00; e_dl = 8'h00;
                        phase = (bm.size() != 0) ? 1 : 0;
                    end
                endcase
                if (wr_valid && rdy && wr_nbytes != 3'd0) begin
                    w.d = wr_data;
                    w.n = wr_nbytes;
                    wq.push_back(w);
                end
            end
        end
    end

    logic [7:0] log_m[$];
    logic [7:0] log_l[$];
    logic       prev_start = 1'b0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("start_m", start_m, e_start);
            chk("start_l", start_l, e_start);
            chk("data_m", data_m, e_dm);
            chk("data_l", data_l, e_dl);
            chk("level_m", level_m, 32'(wq.size()));
            chk("level_l", level_l, 32'(wq.size()));
            chk("ready_m", ready_m, wq.size() < DP);
            chk("ready_l", ready_l, wq.size() < DP);
            chk("ovf_m", ovf_m, e_ovf);
            chk("ovf_l", ovf_l, e_ovf);
            chk("busy_m", obusy_m, (phase != 0) || (wq.size() != 0));
            chk("busy_l", obusy_l, (phase != 0) || (wq.size() != 0));
            if (start_m && !prev_start) begin
                log_m.push_back(data_m);
                log_l.push_back(data_l);
            end
            prev_start = start_m;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] n);
        wr_valid  = 1'b1;
        wr_data   = d;
        wr_nbytes = n;
        step();
        wr_valid  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while ((obusy_m || start_m) && k < maxc) begin
            step();
            k++;
        end
        if (obusy_m || start_m) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", maxc);
        end
    endtask

    logic [7:0] exp1 [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] exp5m[3] = '{8'hB2, 8'hC3, 8'hD4};
    logic [7:0] exp5l[3] = '{8'hD4, 8'hC3, 8'hB2};

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_nbytes = '0;
        flush = 1'b0; ovf_clear = 1'b0; busy = 1'b0;
        step();
        step();
        chk("rst_level", level_m, 0);
        chk("rst_ready", ready_m, 1);
        chk("rst_busy", obusy_m, 0);
        chk("rst_start", start_m, 0);
        rst_n = 1'b1;
        ack_en = 1'b1;
        step();

        // Four bytes MSB first; first start appears after the second edge.
        log_m.delete(); log_l.delete();
        push(32'h41424344, 3'd4);
        step();
        chk("t1_start_e1", start_m, 0);
        step();
        chk("t1_start_e2", start_m, 1);
        chk("t1_first_byte", data_m, 8'h41);
        wait_idle(60);
        chk("t1_nbytes", log_m.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_byte", log_m[i], exp1[i]);
        chk("t1_busy_done", obusy_m, 0);

        // Partial word LSB first, then a zero-length push.
        log_l.delete();
        push(32'h11223344, 3'd2);
        wait_idle(60);
        chk("t2_nbytes", log_l.size(), 2);
        chk("t2_byte0", log_l[0], 8'h44);
        chk("t2_byte1", log_l[1], 8'h33);
        log_l.delete();
        push(32'hDEADBEEF, 3'd0);
        step();
        chk("t2_zero_level", level_m, 0);
        chk("t2_zero_busy", obusy_m, 0);
        step();
        chk("t2_zero_nolog", log_l.size(), 0);

        // Fill while the transmitter is busy.
        busy = 1'b1;
        for (int i = 0; i < DP + 2; i++) push($urandom, 3'd4);
        chk("t3_level_full", level_m, DP);
        chk("t3_ready_low", ready_m, 0);
        chk("t3_ovf_set", ovf_m, 1);
        wr_valid = 1'b1; ovf_clear = 1'b1;
        step();
        wr_valid = 1'b0; ovf_clear = 1'b0;
        chk("t3_set_wins", ovf_m, 1);

        // Busy held in WAIT_TX with clear asserted: nothing happens.
        ack_force = 1'b1;
        repeat (5) begin
            step();
            chk("t4_hold_start", start_m, 0);
        end
        ack_force = 1'b0; ack_en = 1'b0; busy = 1'b0;
        step();
        chk("t4_start_rise", start_m, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_level", level_m, 0);
        chk("t4_flush_ovf", ovf_m, 1);

        // Flush in WAIT_CLR with three queued words and a simultaneous push.
        for (int i = 0; i < 4; i++) push($urandom, 3'd4);
        chk("t5_level3", level_m, 3);
        chk("t5_in_clr", start_m, 1);
        flush = 1'b1; wr_valid = 1'b1; wr_nbytes = 3'd4;
        step();
        flush = 1'b0; wr_valid = 1'b0;
        chk("t5_start", start_m, 0);
        chk("t5_level", level_m, 0);
        chk("t5_busy", obusy_m, 0);
        chk("t5_ovf_kept", ovf_m, 1);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        chk("t5_ovf_clr", ovf_m, 0);
        ack_en = 1'b1;
        log_m.delete(); log_l.delete();
        push(32'hA1B2C3D4, 3'd3);
        wait_idle(60);
        chk("t5_nbytes", log_m.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t5_byte_m", log_m[i], exp5m[i]);
            chk("t5_byte_l", log_l[i], exp5l[i]);
        end

        // Randomised traffic, including oversized counts, flushes and resets.
        repeat (3000) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            wr_valid  = ($urandom_range(0, 2) == 0);
            wr_data   = $urandom;
            wr_nbytes = 3'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 60) == 0);
            ovf_clear = ($urandom_range(0, 15) == 0);
            busy      = ($urandom_range(0, 3) == 0);
            ack_en    = ($urandom_range(0, 3) != 0);
            ack_force = ($urandom_range(0, 19) == 0);
            step();
        end
        rst_n = 1'b1; wr_valid = 1'b0; flush = 1'b0; ovf_clear = 1'b0;
        busy = 1'b0; ack_en = 1'b1; ack_force = 1'b0;
        wait_idle(400);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
